updown_mod_counter: RTL and testbench

- Parametrised successor to the fixed 4-bit down counter.
- Provides a configurable-width, modulo-N up/down counter with enable, synchronous parallel load, prescaled stepping, wrap or saturate mode, and terminal-count/zero flags.
- Intended as the general counter primitive for timers, dividers and sequencers in later designs.

---
 rtl/updown_mod_counter_if.sv | 23 ++
 rtl/updown_mod_counter.sv | 73 +++++++
 tb/tb_updown_mod_counter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives count controls; the slave (the counter) returns the count and flags.
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             zero;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, zero
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, zero
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with prescaled stepping, synchronous load,
// wrap or saturate at the boundaries, a registered terminal-count pulse and a zero flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 15,
    parameter int unsigned RESET_VAL = 15,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned PRESCALE  = 1
) (
    input logic                  clk,
    input logic                  reset,
    updown_mod_counter_if.slave  bus
);
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MaxV    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ResetV  = WIDTH'(RESET_VAL);
    localparam logic [PreW-1:0]  PreLast = PreW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             step;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        step    = 1'b0;

        if (bus.load) begin
            count_d = (bus.load_val > MaxV) ? MaxV : bus.load_val;
            pre_d   = '0;
        end else if (bus.en) begin
            step  = (pre_q == PreLast);
            pre_d = step ? '0 : pre_q + 1'b1;
        end

        // Boundary steps pulse tc in both modes; saturate just refuses to move.
        if (step) begin
            if (bus.up_dn) begin
                if (count_q == MaxV) begin
                    tc_d    = 1'b1;
                    count_d = SATURATE ? MaxV : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = SATURATE ? '0 : MaxV;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= ResetV;
            pre_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.zero  = (count_q == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised scoreboard bench: two counter configurations (wrap/prescaled and
// saturating/unprescaled) driven in lockstep and compared against an arithmetic model.
module tb_updown_mod_counter;
    localparam int MaxA = 9;
    localparam int RstA = 5;
    localparam int PsA  = 3;
    localparam int MaxB = 12;
    localparam int RstB = 12;
    localparam int PsB  = 1;
    localparam int NumCycles = 800;

    typedef struct {
        int cnt;
        int pre;
        bit tc;
    } mst_t;

    logic clk = 1'b0;
    logic reset;

    updown_mod_counter_if #(.WIDTH(4)) ifa ();
    updown_mod_counter_if #(.WIDTH(4)) ifb ();

    updown_mod_counter #(
        .WIDTH(4), .MAX_VAL(MaxA), .RESET_VAL(RstA), .SATURATE(1'b0), .PRESCALE(PsA)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    updown_mod_counter #(
        .WIDTH(4), .MAX_VAL(MaxB), .RESET_VAL(RstB), .SATURATE(1'b1), .PRESCALE(PsB)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    mst_t qa[$];
    mst_t qb[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    // Reference model: modulo arithmetic for wrap, clamping for saturate.
    function automatic mst_t model(input mst_t s, input int maxv, input bit sat, input int ps,
                                   input bit en, input bit up, input bit ld, input int lv);
        mst_t n = s;
        bit   at_edge;
        n.tc = 1'b0;
        if (ld) begin
            n.cnt = (lv > maxv) ? maxv : lv;
            n.pre = 0;
        end else if (en) begin
            n.pre = (s.pre + 1) % ps;
            if (s.pre == ps - 1) begin
                at_edge = up ? (s.cnt == maxv) : (s.cnt == 0);
                n.tc = at_edge;
                if (sat) n.cnt = up ? ((s.cnt + 1 > maxv) ? maxv : s.cnt + 1)
                                    : ((s.cnt - 1 < 0) ? 0 : s.cnt - 1);
                else     n.cnt = up ? (s.cnt + 1) % (maxv + 1)
                                    : (s.cnt + maxv) % (maxv + 1);
            end
        end
        return n;
    endfunction

    task automatic drive(input bit en, input bit up, input bit ld, input logic [3:0] lv);
        ifa.en = en; ifa.up_dn = up; ifa.load = ld; ifa.load_val = lv;
        ifb.en = en; ifb.up_dn = up; ifb.load = ld; ifb.load_val = lv;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_count"}, int'(ifa.count), RstA);
        chk({tag, "_a_tc"},    int'(ifa.tc), 0);
        chk({tag, "_a_zero"},  int'(ifa.zero), 0);
        chk({tag, "_b_count"}, int'(ifb.count), RstB);
        chk({tag, "_b_tc"},    int'(ifb.tc), 0);
    endtask

    // Monitors: the counter presents a result every cycle; pop one expectation per edge.
    always @(posedge clk) begin
        mst_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_count", int'(ifa.count), e.cnt);
            chk("a_tc",    int'(ifa.tc), int'(e.tc));
            chk("a_zero",  int'(ifa.zero), int'(e.cnt == 0));
        end
    end

    always @(posedge clk) begin
        mst_t e;
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_count", int'(ifb.count), e.cnt);
            chk("b_tc",    int'(ifb.tc), int'(e.tc));
            chk("b_zero",  int'(ifb.zero), int'(e.cnt == 0));
        end
    end

    initial begin
        mst_t sa, sb;
        bit   en, up, ld;
        logic [3:0] lv;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        sa = '{cnt: RstA, pre: 0, tc: 1'b0};
        sb = '{cnt: RstB, pre: 0, tc: 1'b0};
        #12;
        chk_reset_state("por");

        up = 1'b1;
        for (int i = 0; i < NumCycles; i++) begin
            @(negedge clk);
            reset = 1'b0;
            en = ($urandom_range(0, 9) < 8);
            ld = ($urandom_range(0, 24) == 0);
            lv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 23) == 0) up = ~up;
            if (i == 0) begin
                ld = 1'b1;
                lv = 4'd12;
            end
            drive(en, up, ld, lv);
            sa = model(sa, MaxA, 1'b0, PsA, en, up, ld, int'(lv));
            sb = model(sb, MaxB, 1'b1, PsB, en, up, ld, int'(lv));
            qa.push_back(sa);
            qb.push_back(sb);

            // Pulse reset between edges, after this edge's results were checked.
            if (i % 97 == 50) begin
                @(posedge clk);
                #3;
                reset = 1'b1;
                #1;
                chk_reset_state("async");
                reset = 1'b0;
                sa = '{cnt: RstA, pre: 0, tc: 1'b0};
                sb = '{cnt: RstB, pre: 0, tc: 1'b0};
            end
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
